// File: rtl/dino_pkg.sv
// Shared types and default constants for the dino sprite blocks (motion, FSM, draw).
package dino_pkg;

    typedef enum logic [2:0] {
        StRun  = 3'd0,
        StDuck = 3'd1,
        StRise = 3'd2,
        StFall = 3'd3,
        StDead = 3'd4
    } dino_state_e;

    localparam int unsigned DinoCoordW   = 11;
    localparam int unsigned DinoXInit    = 50;
    localparam int unsigned DinoGroundY  = 300;
    localparam int unsigned DinoYMin     = 0;
    localparam int unsigned DinoVJump    = 20;
    localparam int unsigned DinoGrav     = 4;
    localparam int unsigned DinoGravHold = 2;
    localparam int unsigned DinoGravFast = 8;
    localparam int unsigned DinoVMax     = 24;

endpackage

// File: rtl/dino_motion_ctrl_if.sv
// Control inputs and sprite-motion outputs of dino_motion_ctrl.
// master: input/collision side driving requests; slave: the motion controller.
interface dino_motion_ctrl_if
    import dino_pkg::*;
#(
    parameter int unsigned COORD_W = DinoCoordW
) ();

    logic               jump;
    logic               duck;
    logic               dead;
    logic               restart;
    logic [COORD_W-1:0] dino_x;
    logic [COORD_W-1:0] dino_y;
    logic [COORD_W-1:0] vel;
    logic [2:0]         state;
    logic               airborne;
    logic               landed;

    modport master (
        output jump, duck, dead, restart,
        input  dino_x, dino_y, vel, state, airborne, landed
    );

    modport slave (
        input  jump, duck, dead, restart,
        output dino_x, dino_y, vel, state, airborne, landed
    );

endinterface

// File: rtl/dino_kinematics_step.sv
// One frame of vertical integration: y + v and v + g, with top clamp,
// terminal-velocity cap and ground touchdown detection. Purely combinational.
module dino_kinematics_step #(
    parameter int unsigned COORD_W  = 11,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned GROUND_Y = 300,
    parameter int unsigned V_MAX    = 24
) (
    input  logic [COORD_W-1:0]        y_i,
    input  logic signed [COORD_W-1:0] v_i,
    input  logic signed [COORD_W-1:0] g_i,
    output logic [COORD_W-1:0]        y_o,
    output logic signed [COORD_W-1:0] v_o,
    output logic                      touchdown_o
);

    // One extra bit so y + v cannot wrap when rising past zero.
    localparam int unsigned W1 = COORD_W + 1;

    localparam logic signed [W1-1:0] YMinE   = W1'(Y_MIN);
    localparam logic signed [W1-1:0] GroundE = W1'(GROUND_Y);
    localparam logic signed [W1-1:0] VMaxE   = W1'(V_MAX);

    logic signed [W1-1:0] y_ext;
    logic signed [W1-1:0] v_ext;
    logic signed [W1-1:0] g_ext;
    logic signed [W1-1:0] y_sum;
    logic signed [W1-1:0] v_sum;
    logic signed [W1-1:0] v_lim;
    logic                 v_pos;
    logic                 top_hit;

    // Integrate, then apply clamps; the top clamp wins over touchdown.
    always_comb begin
        y_ext       = signed'({1'b0, y_i});
        v_ext       = {v_i[COORD_W-1], v_i};
        g_ext       = {g_i[COORD_W-1], g_i};
        y_sum       = y_ext + v_ext;
        v_sum       = v_ext + g_ext;
        v_lim       = (v_sum > VMaxE) ? VMaxE : v_sum;
        v_pos       = !v_i[COORD_W-1] && (v_i != '0);
        top_hit     = y_sum < YMinE;
        touchdown_o = !top_hit && v_pos && (y_sum >= GroundE);
        if (top_hit) begin
            y_o = COORD_W'(Y_MIN);
            v_o = '0;
        end else if (touchdown_o) begin
            y_o = COORD_W'(GROUND_Y);
            v_o = '0;
        end else begin
            y_o = y_sum[COORD_W-1:0];
            v_o = v_lim[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/dino_motion_ctrl.sv
// Vertical-motion controller for the T-rex sprite: jump, duck, fast-fall,
// death freeze and restart, with a one-frame landing pulse.
// Optional feature macro: DINO_VARJUMP_EN (reduced gravity while jump held in RISE).
module dino_motion_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned COORD_W   = DinoCoordW,
    parameter int unsigned X_INIT    = DinoXInit,
    parameter int unsigned GROUND_Y  = DinoGroundY,
    parameter int unsigned Y_MIN     = DinoYMin,
    parameter int unsigned V_JUMP    = DinoVJump,
    parameter int unsigned GRAV      = DinoGrav,
    parameter int unsigned GRAV_HOLD = DinoGravHold,
    parameter int unsigned GRAV_FAST = DinoGravFast,
    parameter int unsigned V_MAX     = DinoVMax
) (
    input  logic               FrameClk,
    input  logic               rst,
    dino_motion_ctrl_if.slave  bus
);

    localparam logic signed [COORD_W-1:0] GNorm    = COORD_W'(GRAV);
    localparam logic signed [COORD_W-1:0] GHold    = COORD_W'(GRAV_HOLD);
    localparam logic signed [COORD_W-1:0] GFast    = COORD_W'(GRAV_FAST);
    localparam logic signed [COORD_W-1:0] VLaunch  = -COORD_W'(V_JUMP);
    localparam logic [COORD_W-1:0]        GroundYC = COORD_W'(GROUND_Y);

    dino_state_e               state_q, state_d;
    logic [COORD_W-1:0]        y_q, y_d;
    logic signed [COORD_W-1:0] v_q, v_d;
    logic                      landed_q, landed_d;
    logic                      airborne_q, airborne_d;

    logic                      hold_jump;
    logic signed [COORD_W-1:0] grav;
    logic [COORD_W-1:0]        k_y;
    logic signed [COORD_W-1:0] k_v;
    logic                      k_touchdown;

    // Select active gravity: fast-fall beats jump-hold beats normal.
    always_comb begin
`ifdef DINO_VARJUMP_EN
        hold_jump = (state_q == StRise) && bus.jump;
`else
        hold_jump = 1'b0;
`endif
        if (bus.duck) begin
            grav = GFast;
        end else if (hold_jump) begin
            grav = GHold;
        end else begin
            grav = GNorm;
        end
    end

    dino_kinematics_step #(
        .COORD_W  (COORD_W),
        .Y_MIN    (Y_MIN),
        .GROUND_Y (GROUND_Y),
        .V_MAX    (V_MAX)
    ) u_step (
        .y_i         (y_q),
        .v_i         (v_q),
        .g_i         (grav),
        .y_o         (k_y),
        .v_o         (k_v),
        .touchdown_o (k_touchdown)
    );

    // Next-state: dead > restart > duck > jump; restart only acts from DEAD.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        v_d      = v_q;
        landed_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.dead) begin
                    state_d = StDead;
                end else if (bus.duck) begin
                    state_d = StDuck;
                end else if (bus.jump) begin
                    state_d = StRise;
                    v_d     = VLaunch;
                end
            end
            StDuck: begin
                if (bus.dead) begin
                    state_d = StDead;
                end else if (!bus.duck) begin
                    state_d = StRun;
                end
            end
            StRise, StFall: begin
                if (bus.dead) begin
                    state_d = StDead;
                end else begin
                    y_d = k_y;
                    v_d = k_v;
                    if (k_touchdown) begin
                        landed_d = 1'b1;
                        state_d  = bus.duck ? StDuck : StRun;
                    end else if (!k_v[COORD_W-1]) begin
                        // Covers the apex and the top clamp (which zeroes v).
                        state_d = StFall;
                    end
                end
            end
            StDead: begin
                if (!bus.dead && bus.restart) begin
                    state_d = StRun;
                    y_d     = GroundYC;
                    v_d     = '0;
                end
            end
            default: begin
                state_d = StRun;
                y_d     = GroundYC;
                v_d     = '0;
            end
        endcase
        airborne_d = (state_d == StRise) || (state_d == StFall);
    end

    // State and all registered outputs; rst clears them without a clock edge.
    always_ff @(posedge FrameClk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            y_q        <= GroundYC;
            v_q        <= '0;
            landed_q   <= 1'b0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            v_q        <= v_d;
            landed_q   <= landed_d;
            airborne_q <= airborne_d;
        end
    end

    assign bus.dino_x   = COORD_W'(X_INIT);
    assign bus.dino_y   = y_q;
    assign bus.vel      = v_q;
    assign bus.state    = state_q;
    assign bus.airborne = airborne_q;
    assign bus.landed   = landed_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Bench for dino_motion_ctrl: directed scenarios plus random frames, two DUTs
// (default parameters and Y_MIN=270) checked against a frame-level integer model.
module tb_dino_motion_ctrl;

    localparam int M_RUN  = 0;
    localparam int M_DUCK = 1;
    localparam int M_RISE = 2;
    localparam int M_FALL = 3;
    localparam int M_DEAD = 4;

`ifdef DINO_VARJUMP_EN
    localparam bit VarJump = 1'b1;
`else
    localparam bit VarJump = 1'b0;
`endif

    typedef struct {
        int st;
        int y;
        int v;
        bit landed;
    } mdl_t;

    logic FrameClk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    mdl_t ma, mb;
    int   exp_seq [12] = '{300, 280, 264, 252, 244, 240, 240, 244, 252, 264, 280, 300};

    always #5 FrameClk = ~FrameClk;

    dino_motion_ctrl_if bus_a ();
    dino_motion_ctrl_if bus_b ();

    dino_motion_ctrl dut_a (
        .FrameClk (FrameClk),
        .rst      (rst),
        .bus      (bus_a)
    );

    dino_motion_ctrl #(
        .Y_MIN (270)
    ) dut_b (
        .FrameClk (FrameClk),
        .rst      (rst),
        .bus      (bus_b)
    );

    function automatic mdl_t model_reset();
        mdl_t r;
        r.st = M_RUN;
        r.y = 300;
        r.v = 0;
        r.landed = 1'b0;
        return r;
    endfunction

    // One frame of the sprite's rules in plain integer arithmetic.
    function automatic mdl_t model_next(mdl_t s, bit j, bit d, bit dd, bit r, int ymin);
        mdl_t n;
        int g, yn, vn;
        n = s;
        n.landed = 1'b0;
        if (s.st == M_DEAD) begin
            if (!dd && r) begin
                n.st = M_RUN;
                n.y  = 300;
                n.v  = 0;
            end
        end else if (dd) begin
            n.st = M_DEAD;
        end else if (s.st == M_RUN) begin
            if (d) n.st = M_DUCK;
            else if (j) begin
                n.st = M_RISE;
                n.v  = -20;
            end
        end else if (s.st == M_DUCK) begin
            if (!d) n.st = M_RUN;
        end else begin
            g  = d ? 8 : ((VarJump && s.st == M_RISE && j) ? 2 : 4);
            yn = s.y + s.v;
            vn = s.v + g;
            if (vn > 24) vn = 24;
            if (yn < ymin) begin
                n.y  = ymin;
                n.v  = 0;
                n.st = M_FALL;
            end else if (s.v > 0 && yn >= 300) begin
                n.y      = 300;
                n.v      = 0;
                n.landed = 1'b1;
                n.st     = d ? M_DUCK : M_RUN;
            end else begin
                n.y = yn;
                n.v = vn;
                if (vn >= 0) n.st = M_FALL;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_one(input string p, input logic [2:0] st, input logic [10:0] x,
                             input logic [10:0] y, input logic [10:0] vel, input logic lnd,
                             input logic air, input mdl_t m);
        chk({p, ".state"}, {29'd0, st}, m.st);
        chk({p, ".x"}, {21'd0, x}, 50);
        chk({p, ".y"}, {21'd0, y}, m.y);
        chk({p, ".vel"}, {{21{vel[10]}}, vel}, m.v);
        chk({p, ".landed"}, {31'd0, lnd}, {31'd0, m.landed});
        chk({p, ".airborne"}, {31'd0, air}, (m.st == M_RISE || m.st == M_FALL) ? 1 : 0);
    endtask

    task automatic check_all();
        check_one("a", bus_a.state, bus_a.dino_x, bus_a.dino_y, bus_a.vel, bus_a.landed,
                  bus_a.airborne, ma);
        check_one("b", bus_b.state, bus_b.dino_x, bus_b.dino_y, bus_b.vel, bus_b.landed,
                  bus_b.airborne, mb);
    endtask

    // Advance one frame: inputs are already stable; sample outputs 1 time unit later.
    task automatic step();
        @(posedge FrameClk);
        ma = model_next(ma, bus_a.jump, bus_a.duck, bus_a.dead, bus_a.restart, 0);
        mb = model_next(mb, bus_b.jump, bus_b.duck, bus_b.dead, bus_b.restart, 270);
        #1;
        check_all();
    endtask

    initial begin
        int apex;
        bit seen;
        rst = 1'b0;
        bus_a.jump = 1'b0; bus_a.duck = 1'b0; bus_a.dead = 1'b0; bus_a.restart = 1'b0;
        bus_b.jump = 1'b0; bus_b.duck = 1'b0; bus_b.dead = 1'b0; bus_b.restart = 1'b0;
        ma = model_reset();
        mb = model_reset();

        // Reset values before any clock edge.
        #2 rst = 1'b1;
        #2 check_all();
        #8 rst = 1'b0;

        // Single jump pulse: full trajectory.
        bus_a.jump = 1'b1;
        step();
        bus_a.jump = 1'b0;
        chk("seq0", {21'd0, bus_a.dino_y}, exp_seq[0]);
        for (int i = 1; i < 12; i++) begin
            step();
            chk($sformatf("seq%0d", i), {21'd0, bus_a.dino_y}, exp_seq[i]);
            if (i == 4) chk("rise_before_apex", {29'd0, bus_a.state}, M_RISE);
            if (i == 5) chk("fall_at_apex", {29'd0, bus_a.state}, M_FALL);
        end
        chk("landed_final", {31'd0, bus_a.landed}, 1);
        step();
        chk("landed_one_frame", {31'd0, bus_a.landed}, 0);

        // Duck from the apex: fast-fall capped at 24, lands in DUCK.
        bus_a.jump = 1'b1;
        step();
        bus_a.jump = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("apex_vel", {{21{bus_a.vel[10]}}, bus_a.vel}, 0);
        bus_a.duck = 1'b1;
        step(); chk("ff_vel1", {{21{bus_a.vel[10]}}, bus_a.vel}, 8);
        step(); chk("ff_vel2", {{21{bus_a.vel[10]}}, bus_a.vel}, 16);
        step(); chk("ff_vel3", {{21{bus_a.vel[10]}}, bus_a.vel}, 24);
        step(); chk("ff_vel_cap", {{21{bus_a.vel[10]}}, bus_a.vel}, 24);
        chk("ff_y_cap", {21'd0, bus_a.dino_y}, 288);
        step();
        chk("ff_land_duck", {29'd0, bus_a.state}, M_DUCK);
        chk("ff_land_pulse", {31'd0, bus_a.landed}, 1);
        bus_a.duck = 1'b0;
        step();
        chk("unduck_run", {29'd0, bus_a.state}, M_RUN);

        // Death mid-air at y=252, then restart.
        bus_a.jump = 1'b1;
        step();
        bus_a.jump = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus_a.dead = 1'b1;
        step();
        chk("dead_state", {29'd0, bus_a.state}, M_DEAD);
        chk("dead_y", {21'd0, bus_a.dino_y}, 252);
        bus_a.restart = 1'b1;
        step();
        chk("dead_outranks", {29'd0, bus_a.state}, M_DEAD);
        bus_a.dead = 1'b0;
        bus_a.restart = 1'b0;
        step();
        chk("dead_frozen_y", {21'd0, bus_a.dino_y}, 252);
        bus_a.restart = 1'b1;
        step();
        bus_a.restart = 1'b0;
        chk("restart_state", {29'd0, bus_a.state}, M_RUN);
        chk("restart_y", {21'd0, bus_a.dino_y}, 300);
        chk("restart_vel", {{21{bus_a.vel[10]}}, bus_a.vel}, 0);

        // Top clamp with Y_MIN=270 on the second instance.
        bus_b.jump = 1'b1;
        step();
        bus_b.jump = 1'b0;
        step();
        step();
        chk("clamp_y", {21'd0, bus_b.dino_y}, 270);
        chk("clamp_vel", {{21{bus_b.vel[10]}}, bus_b.vel}, 0);
        chk("clamp_fall", {29'd0, bus_b.state}, M_FALL);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                step();
                if (bus_b.landed === 1'b1) seen = 1'b1;
            end
        end
        chk("clamp_landed", {31'd0, seen}, 1);
        chk("clamp_land_y", {21'd0, bus_b.dino_y}, 300);

        // Jump held through RISE; released once falling.
        bus_a.jump = 1'b1;
        apex = 300;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                step();
                if (int'(bus_a.dino_y) < apex) apex = int'(bus_a.dino_y);
                if (bus_a.state !== 3'd2) bus_a.jump = 1'b0;
                if (bus_a.landed === 1'b1) seen = 1'b1;
            end
        end
        chk("held_landed", {31'd0, seen}, 1);
`ifdef DINO_VARJUMP_EN
        chk("varjump_apex_higher", {31'd0, apex < 240}, 1);
`else
        chk("held_apex", apex, 240);
`endif

        // Reset in the middle of RISE acts immediately.
        bus_a.jump = 1'b1;
        step();
        bus_a.jump = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        ma = model_reset();
        mb = model_reset();
        check_all();
        chk("rst_mid_rise_y", {21'd0, bus_a.dino_y}, 300);
        #2 rst = 1'b0;
        // Jump and duck together on ground: duck wins.
        bus_a.jump = 1'b1;
        bus_a.duck = 1'b1;
        step();
        chk("jd_duck", {29'd0, bus_a.state}, M_DUCK);
        chk("jd_no_launch", {{21{bus_a.vel[10]}}, bus_a.vel}, 0);
        bus_a.jump = 1'b0;
        bus_a.duck = 1'b0;
        step();

        // Random frames on both instances.
        for (int i = 0; i < 400; i++) begin
            bus_a.jump    = ($urandom_range(1, 0) == 1);
            bus_a.duck    = ($urandom_range(3, 0) == 0);
            bus_a.dead    = ($urandom_range(31, 0) == 0);
            bus_a.restart = ($urandom_range(3, 0) == 0);
            bus_b.jump    = ($urandom_range(1, 0) == 1);
            bus_b.duck    = ($urandom_range(3, 0) == 0);
            bus_b.dead    = ($urandom_range(31, 0) == 0);
            bus_b.restart = ($urandom_range(3, 0) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dino_motion_ctrl.md
# dino_motion_ctrl

Parametrised vertical-motion controller for the T-rex sprite. It integrates signed velocity under configurable gravity once per frame and supports jump, duck, in-air fast-fall, death freeze and restart. It also produces a one-frame landing pulse. It sits between the input/collision logic and the dino FSM/draw path, and supplies sprite X/Y and motion state every FrameClk.

## Interface
- COORD_W, 11: width of the X/Y coordinates; velocity is signed, COORD_W bits.
- X_INIT, 50: fixed horizontal sprite position.
- GROUND_Y, 300: Y value of the standing sprite; Y grows downward.
- Y_MIN, 0: top clamp for Y.
- V_JUMP, 20: launch speed; velocity becomes −V_JUMP at takeoff.
- GRAV, 4: per-frame velocity increment.
- GRAV_HOLD, 2: increment while jump is held during RISE (only with DINO_VARJUMP_EN).
- GRAV_FAST, 8: increment while duck is held in air.
- V_MAX, 24: terminal downward velocity.
- FrameClk  in  1  frame-rate clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- jump  in  1  jump request, level-sampled.
- duck  in  1  duck request, level-sampled.
- dead  in  1  collision flag from the obstacle logic.
- restart  in  1  leave DEAD.
- dino_x  out  COORD_W  always X_INIT.
- dino_y  out  COORD_W  current sprite Y.
- vel  out  COORD_W  signed current velocity.
- state  out  3  RUN=0, DUCK=1, RISE=2, FALL=3, DEAD=4.
- airborne  out  1  high when state is RISE or FALL.
- landed  out  1  one-frame pulse on touchdown.

## Operation
- Reset values: state=RUN, dino_y=GROUND_Y, vel=0, landed=0, dino_x=X_INIT.
- Inputs are evaluated in this priority order: dead > restart > duck > jump.
- RUN:
  - dead → DEAD.
  - duck → DUCK.
  - jump → RISE, with vel←−V_JUMP and dino_y unchanged on that edge.
- DUCK:
  - duck=0 → RUN.
  - jump is ignored while in DUCK.
- RISE/FALL, on each edge:
  - Active gravity g is selected as GRAV_FAST if duck, else GRAV_HOLD if (RISE and jump and DINO_VARJUMP_EN), else GRAV.
  - y_n = dino_y + vel, computed at COORD_W+1 bits signed.
  - v_n = min(vel + g, V_MAX).
- Top clamp: if y_n < Y_MIN, then dino_y←Y_MIN and vel←0.
- Landing: if vel>0 and y_n ≥ GROUND_Y, then dino_y←GROUND_Y, vel←0, landed←1, and state←DUCK if duck else RUN.
- Otherwise dino_y←y_n, vel←v_n, and RISE→FALL once v_n ≥ 0.
- DEAD:
  - dino_y and vel are frozen.
  - restart → RUN with dino_y←GROUND_Y and vel←0.
  - dead held high keeps the block in DEAD, since dead outranks restart.
- Simultaneous jump+duck on ground: duck wins.
- Holding jump after landing relaunches on the next edge; this is auto-repeat by design.

## Timing
- Every output is registered; inputs take effect on the first FrameClk edge at which they are sampled high.
- Latency from input to output change is one edge.
- landed is high for exactly one FrameClk period.
- rst asserted mid-jump returns all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- DINO_VARJUMP_EN defined: releasing jump during RISE switches gravity from GRAV_HOLD back to GRAV, giving variable jump height.
- DINO_VARJUMP_EN undefined: GRAV applies throughout RISE, and GRAV_HOLD is unused.

## Structure
- dino_pkg holds the state enum (RUN..DEAD) and the default-constant localparams shared with the FSM and draw blocks.
- One sub-module, dino_kinematics_step: combinational logic that takes y, v and g and produces clamped y_n, v_n and a touchdown flag.
- The state machine and registers stay in the top level.

## Test plan
- Defaults, DINO_VARJUMP_EN off, single jump pulse:
  - dino_y sequence: 300, 280, 264, 252, 244, 240, 240, 244, 252, 264, 280, 300.
  - landed high on the final edge.
  - state changes RISE→FALL on the edge that produces the first 240.
- DINO_VARJUMP_EN on, jump held throughout: the apex is strictly above 240 (smaller Y).
- duck asserted at the apex: vel grows by 8 per frame and is capped at 24; landing lands in DUCK.
- dead pulsed mid-air at dino_y=252: state=DEAD and y stays 252; restart → RUN, y=300, vel=0.
- Y_MIN=270, jump: y clamps at 270, vel=0, state goes to FALL, then it lands normally.
- rst asserted mid-RISE: outputs return to reset values at once; jump and duck both held on ground → DUCK, no launch.
